// File: rtl/sram_1rw1r_sync_param.sv
// Parametrised 1RW + 1R synchronous SRAM with a post-reset clear sweep, read-valid strobes and collision flag.
// Optional macro SRAM_BYPASS_EN: on a same-address write/read collision port 1 returns the merged new word.
module sram_1rw1r_sync_param #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 9,
    parameter int DEPTH          = 1 << ADDR_WIDTH,
    parameter int MASK_WIDTH     = 8,
    parameter int NUM_WMASKS     = DATA_WIDTH / MASK_WIDTH,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    output logic                  dvalid0,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic                  dvalid1,
    output logic                  ready,
    output logic                  collision
);

    generate
        if ((DATA_WIDTH % MASK_WIDTH != 0) || (NUM_WMASKS * MASK_WIDTH != DATA_WIDTH)) begin : g_bad_mask
            $error("DATA_WIDTH must equal NUM_WMASKS * MASK_WIDTH");
        end
        if (DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
            $error("DEPTH must not exceed 2**ADDR_WIDTH");
        end
    endgenerate

    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic                  ready_q;
    logic [DATA_WIDTH-1:0] dout0_q, dout0_d;
    logic [DATA_WIDTH-1:0] dout1_q, dout1_d;
    logic                  dvalid0_q, dvalid0_d;
    logic                  dvalid1_q, dvalid1_d;
    logic                  collision_q, collision_d;

    logic                  wr0_s, rd0_s, rd1_s, in0_s, in1_s, coll_s, clr_s;
    logic [DATA_WIDTH-1:0] rd0_word_s, rd1_word_s;

    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NUM_WMASKS-1:0] mask
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < NUM_WMASKS; i++) begin
            if (mask[i]) begin
                res[i*MASK_WIDTH +: MASK_WIDTH] = new_word[i*MASK_WIDTH +: MASK_WIDTH];
            end else begin
                res[i*MASK_WIDTH +: MASK_WIDTH] = old_word[i*MASK_WIDTH +: MASK_WIDTH];
            end
        end
        return res;
    endfunction

    // Request decode: chip selects only count once the array is ready
    always_comb begin
        clr_s  = (state_q == ST_CLEAR);
        wr0_s  = ready_q & ~csb0 & ~web0;
        rd0_s  = ready_q & ~csb0 & web0;
        rd1_s  = ready_q & ~csb1;
        in0_s  = ({1'b0, addr0} < DEPTH_W);
        in1_s  = ({1'b0, addr1} < DEPTH_W);
        coll_s = wr0_s & rd1_s & (addr0 == addr1);
    end

    // Read data selection; out-of-range addresses read as zero
    always_comb begin
        rd0_word_s = {DATA_WIDTH{1'b0}};
        rd1_word_s = {DATA_WIDTH{1'b0}};
        if (in0_s) begin
            rd0_word_s = mem_q[addr0];
        end else begin
            rd0_word_s = {DATA_WIDTH{1'b0}};
        end
        if (in1_s) begin
`ifdef SRAM_BYPASS_EN
            if (coll_s) begin
                rd1_word_s = merge_lanes(mem_q[addr1], din0, wmask0);
            end else begin
                rd1_word_s = mem_q[addr1];
            end
`else
            rd1_word_s = mem_q[addr1];
`endif
        end else begin
            rd1_word_s = {DATA_WIDTH{1'b0}};
        end
    end

    // Next-state for the registered read outputs and strobes
    always_comb begin
        dout0_d     = dout0_q;
        dout1_d     = dout1_q;
        dvalid0_d   = rd0_s;
        dvalid1_d   = rd1_s;
        collision_d = coll_s;
        if (rd0_s) begin
            dout0_d = rd0_word_s;
        end else begin
            dout0_d = dout0_q;
        end
        if (rd1_s) begin
            dout1_d = rd1_word_s;
        end else begin
            dout1_d = dout1_q;
        end
    end

    // Clear-sweep FSM and ready flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            cnt_q   <= {ADDR_WIDTH{1'b0}};
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    cnt_q <= cnt_q + ADDR_WIDTH'(1);
                    if (cnt_q == LAST_ADDR) begin
                        state_q <= ST_READY;
                        ready_q <= 1'b1;
                    end
                end
                ST_READY: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_CLEAR;
                    cnt_q   <= {ADDR_WIDTH{1'b0}};
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            dout0_q     <= {DATA_WIDTH{1'b0}};
            dout1_q     <= {DATA_WIDTH{1'b0}};
            dvalid0_q   <= 1'b0;
            dvalid1_q   <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            dout0_q     <= dout0_d;
            dout1_q     <= dout1_d;
            dvalid0_q   <= dvalid0_d;
            dvalid1_q   <= dvalid1_d;
            collision_q <= collision_d;
        end
    end

    // Array write port: sweep zeroing has the port while not ready
    always_ff @(posedge clk) begin
        if (!rst && clr_s) begin
            mem_q[cnt_q] <= {DATA_WIDTH{1'b0}};
        end else if (!rst && wr0_s && in0_s) begin
            mem_q[addr0] <= merge_lanes(mem_q[addr0], din0, wmask0);
        end
    end

    assign dout0     = dout0_q;
    assign dout1     = dout1_q;
    assign dvalid0   = dvalid0_q;
    assign dvalid1   = dvalid1_q;
    assign ready     = ready_q;
    assign collision = collision_q;

endmodule

// File: tb/tb_sram_1rw1r_sync_param.sv
// Self-checking bench for sram_1rw1r_sync_param against a word-array reference model.
module tb_sram_1rw1r_sync_param;

    localparam int DW    = 32;
    localparam int AW    = 9;
    localparam int DEPTH = 512;
    localparam int MW    = 8;
    localparam int NM    = DW / MW;

    logic          clk;
    logic          rst;
    logic          csb0, web0, csb1;
    logic [NM-1:0] wmask0;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] din0;
    logic [DW-1:0] dout0, dout1;
    logic          dvalid0, dvalid1, ready, collision;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model [DEPTH];
    bit            m_ready;
    int            m_left;
    logic [DW-1:0] exp_d0, exp_d1;

    sram_1rw1r_sync_param #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
        .MASK_WIDTH(MW), .NUM_WMASKS(NM), .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk), .rst(rst),
        .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
        .dout0(dout0), .dvalid0(dvalid0),
        .csb1(csb1), .addr1(addr1), .dout1(dout1), .dvalid1(dvalid1),
        .ready(ready), .collision(collision)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                                 input logic [NM-1:0] m);
        logic [DW-1:0] r;
        r = old_w;
        for (int i = 0; i < NM; i++) if (m[i]) r[i*MW +: MW] = new_w[i*MW +: MW];
        return r;
    endfunction

    // One clock: predict from the model, advance the DUT, compare at the falling edge.
    task automatic do_cycle(input string tag);
        bit ev0, ev1, ec, wr;
        ev0 = 1'b0; ev1 = 1'b0; ec = 1'b0; wr = 1'b0;
        if (rst) begin
            exp_d0 = '0; exp_d1 = '0;
            m_ready = 1'b0; m_left = DEPTH;
        end else begin
            ev0 = m_ready && !csb0 && web0;
            ev1 = m_ready && !csb1;
            wr  = m_ready && !csb0 && !web0;
            ec  = wr && ev1 && (addr0 == addr1);
            if (ev0) exp_d0 = model[addr0];
            if (ev1) begin
`ifdef SRAM_BYPASS_EN
                exp_d1 = ec ? lane_merge(model[addr1], din0, wmask0) : model[addr1];
`else
                exp_d1 = model[addr1];
`endif
            end
            if (wr) model[addr0] = lane_merge(model[addr0], din0, wmask0);
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_ready = 1'b1;
                    for (int i = 0; i < DEPTH; i++) model[i] = '0;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".ready"},     {31'd0, ready},     {31'd0, m_ready});
        chk({tag, ".dvalid0"},   {31'd0, dvalid0},   {31'd0, ev0});
        chk({tag, ".dvalid1"},   {31'd0, dvalid1},   {31'd0, ev1});
        chk({tag, ".collision"}, {31'd0, collision}, {31'd0, ec});
        chk({tag, ".dout0"},     dout0,              exp_d0);
        chk({tag, ".dout1"},     dout1,              exp_d1);
    endtask

    task automatic idle();
        csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1; wmask0 = '0;
        addr0 = '0; addr1 = '0; din0 = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        m_ready = 1'b0; m_left = DEPTH; exp_d0 = '0; exp_d1 = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;

        do_cycle("reset");
        rst = 1'b0;

        // Sweep, with a write and reads attempted while not ready
        for (int k = 0; k < DEPTH; k++) begin
            if (k == 5) begin
                csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; addr0 = 9'd3; din0 = 32'hFFFF_FFFF;
                csb1 = 1'b0; addr1 = 9'd3;
            end else begin
                idle();
            end
            do_cycle("sweep");
        end

        idle();
        csb0 = 1'b0; web0 = 1'b1; addr0 = 9'd3; csb1 = 1'b0; addr1 = 9'd100;
        do_cycle("post_sweep_rd");
        chk("addr3_zero", dout0, 32'h0000_0000);

        // Masked writes then port-1 read
        idle();
        csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'b1111; addr0 = 9'd5; din0 = 32'hDEAD_BEEF;
        do_cycle("mwr1");
        wmask0 = 4'b0101; din0 = 32'h1122_3344;
        do_cycle("mwr2");
        idle();
        csb1 = 1'b0; addr1 = 9'd5; csb0 = 1'b0; web0 = 1'b1; addr0 = 9'd5;
        do_cycle("mrd");
        chk("masked_word", dout1, 32'hDE22_BE44);

        idle();
        for (int k = 0; k < 3; k++) do_cycle("deselect");
        chk("hold_dout1", dout1, 32'hDE22_BE44);

        // Legal no-op write with all lanes disabled
        csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'b0000; addr0 = 9'd5; din0 = 32'h0;
        do_cycle("noop_wr");

        // Collision at addr 7
        idle();
        csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; addr0 = 9'd7; din0 = 32'hAAAA_AAAA;
        do_cycle("coll_pre");
        wmask0 = 4'b0011; din0 = 32'h5555_5555; csb1 = 1'b0; addr1 = 9'd7;
        do_cycle("coll");
`ifdef SRAM_BYPASS_EN
        chk("coll_dout1", dout1, 32'hAAAA_5555);
`else
        chk("coll_dout1", dout1, 32'hAAAA_AAAA);
`endif
        idle();
        csb0 = 1'b0; web0 = 1'b1; addr0 = 9'd7; csb1 = 1'b0; addr1 = 9'd7;
        do_cycle("dual_rd");
        chk("after_coll", dout0, 32'hAAAA_5555);

        // Randomised traffic on a narrow address window to provoke collisions
        for (int k = 0; k < 400; k++) begin
            csb0   = ($urandom_range(0, 3) == 0);
            web0   = $urandom_range(0, 1) == 1;
            wmask0 = NM'($urandom);
            addr0  = AW'($urandom_range(0, 15));
            din0   = $urandom;
            csb1   = ($urandom_range(0, 3) == 0);
            addr1  = AW'($urandom_range(0, 15));
            do_cycle("rand");
        end

        // Reset mid-sweep restarts the full clear
        idle();
        csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; addr0 = 9'd511; din0 = 32'h1234_5678;
        do_cycle("wr511");
        idle();
        rst = 1'b1;
        do_cycle("rst2");
        rst = 1'b0;
        for (int k = 0; k < 100; k++) do_cycle("sweep_a");
        rst = 1'b1;
        do_cycle("rst3");
        rst = 1'b0;
        for (int k = 0; k < DEPTH; k++) do_cycle("sweep_b");
        csb0 = 1'b0; web0 = 1'b1; addr0 = 9'd511; csb1 = 1'b0; addr1 = 9'd7;
        do_cycle("rd511");
        chk("addr511_zero", dout0, 32'h0000_0000);
        chk("addr7_zero",   dout1, 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_1rw1r_sync_param.md
Name: sram_1rw1r_sync_param

Overview:
- Parametrised, synthesizable, single-clock 1RW + 1R SRAM model; successor to the fixed 32x512 OpenRAM blackbox macro.
- Adds a post-reset clear sweep with a ready indication, per-port read-valid strobes, and same-address collision reporting.
- Used for RTL simulation and FPGA prototyping wherever the hard SRAM macro sits in the design.

Parameters:
- DATA_WIDTH, 32, word width in bits.
- ADDR_WIDTH, 9, address width.
- DEPTH, 1<<ADDR_WIDTH, number of words; must be at most 2^ADDR_WIDTH.
- MASK_WIDTH, 8, bits per write-mask lane. DATA_WIDTH must be a multiple of MASK_WIDTH; elaboration error otherwise.
- NUM_WMASKS, DATA_WIDTH/MASK_WIDTH, number of write-mask lanes (derived).
- CLEAR_ON_RESET, 1, 1 = zero the whole array after reset; 0 = skip the sweep.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- csb0  in  1  port 0 chip select, active low.
- web0  in  1  port 0 write enable, active low.
- wmask0  in  NUM_WMASKS  per-lane write enable, active high.
- addr0  in  ADDR_WIDTH  port 0 address.
- din0  in  DATA_WIDTH  port 0 write data.
- dout0  out  DATA_WIDTH  port 0 read data (registered).
- dvalid0  out  1  one-cycle strobe: dout0 was updated on this edge.
- csb1  in  1  port 1 chip select, active low.
- addr1  in  ADDR_WIDTH  port 1 address.
- dout1  out  DATA_WIDTH  port 1 read data (registered).
- dvalid1  out  1  one-cycle strobe: dout1 was updated on this edge.
- ready  out  1  high when the array accepts requests.
- collision  out  1  one-cycle strobe: port 1 read and port 0 write hit the same address on the same edge.

Behaviour:
- Reset (rst=1 sampled at an edge): dout0=0, dout1=0, dvalid0=0, dvalid1=0, collision=0, ready=0, clear counter=0. Array contents are not reset by rst itself.
- FSM states: CLEAR, READY.
  - rst → CLEAR if CLEAR_ON_RESET=1, otherwise READY.
  - CLEAR: each edge writes 0 to mem[cnt] and increments cnt. On the edge that writes cnt==DEPTH-1, go to READY. ready rises on that same edge.
  - The sweep takes exactly DEPTH cycles.
- rst asserted mid-sweep restarts the sweep at cnt=0. rst has priority over all other activity.
- While ready=0:
  - csb0/csb1 are ignored.
  - No user writes occur.
  - dvalid0, dvalid1 and collision stay 0.
- Port 0, with ready=1 and csb0=0:
  - Write (web0=0): for each lane i with wmask0[i]=1, mem[addr0][i*MASK_WIDTH +: MASK_WIDTH] takes din0 on that edge. Unmasked lanes are unchanged.
  - On a write, dout0 holds its value and dvalid0=0.
  - wmask0 all-zero with web0=0 is a legal no-op write.
  - Read (web0=1): dout0 = mem[addr0] on the same edge. Read latency is 1 cycle; dvalid0=1 for one cycle.
- Port 1, with ready=1 and csb1=0: dout1 = mem[addr1] on the same edge; dvalid1=1 for one cycle.
- Deselected port: dout holds its last value; dvalid=0.
- Same-address collision: port 0 write, port 1 read, addr0==addr1 on the same edge.
  - collision=1 for that one cycle.
  - dout1 follows the rules under Optional Feature.
- Port 0 read and port 1 read at the same address: both return the stored word; no collision.
- Address ≥ DEPTH (only possible when DEPTH < 2^ADDR_WIDTH):
  - Write: ignored.
  - Read: returns 0 with dvalid still asserted.
- No X propagation: every output is driven from reset onward.

Optional Feature:
- Macro: SRAM_BYPASS_EN.
- Defined: on a collision, dout1 returns the merged new word, i.e. the enabled lanes from din0 and the remaining lanes from the old stored word (write-through). collision is still asserted.
- Undefined: on a collision, dout1 returns the old stored word (read-before-write).

Test Plan:
- Reset sweep, DEPTH=512, CLEAR_ON_RESET=1: rst for 1 cycle → ready=0 for 512 cycles, then ready=1; read of any address gives 0x00000000 with dvalid=1.
- Rst mid-sweep: assert rst at cnt=100 → ready stays low for a full 512 more cycles; address 511 reads 0.
- Masked write: write 0xDEADBEEF to addr 5 with wmask0=4'b1111, then 0x11223344 with wmask0=4'b0101 → port 1 reads 0xDE22BE44 one cycle later with dvalid1=1.
- Hold on deselect: after reading 0xDE22BE44, set csb0=csb1=1 for 3 cycles → both douts hold, dvalid0=dvalid1=0.
- Collision at addr 7 (old value 0xAAAAAAAA): write 0x55555555 with wmask0=4'b0011 while port 1 reads addr 7 → collision=1 for one cycle; dout1=0xAAAAAAAA without SRAM_BYPASS_EN, 0xAAAA5555 with it.
- Requests during the sweep: write 0xFFFFFFFF to addr 3 while ready=0 → ignored; after ready=1, addr 3 reads 0x00000000.
